// File: rtl/multi_answer_checker_pkg.sv
// Shared definitions for the processor-testbed answer checker:
// FSM encoding, bus byte-swap helper and the default monitored address.
package tb_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_TEST_PORT = 0;
  localparam int MAX_DATA_W        = 128;

  // Reverses the lowest nbytes bytes of d; bytes above nbytes come back as zero.
  function automatic logic [MAX_DATA_W-1:0] byteswap(input logic [MAX_DATA_W-1:0] d,
                                                     input int nbytes);
    byteswap = '0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < nbytes) begin
        byteswap[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
      end
    end
  endfunction

endpackage

// File: rtl/multi_answer_checker_if.sv
// Snooped data-memory write bus plus the expected-answer load port.
interface multi_answer_checker_if
  import tb_check_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) ();

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;

  modport master (output addr, data, wen, ld_en, ld_idx, ld_data);
  modport slave  (input  addr, data, wen, ld_en, ld_idx, ld_data);

endinterface

// File: rtl/multi_answer_checker_ans_table.sv
// Expected-answer register file: one write port, one asynchronous read port.
// No reset, so loaded answers survive a checker reset.
module ans_table
  import tb_check_pkg::*;
#(
  parameter int NUM_ANS = 8,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_ANS);

  logic [DATA_W-1:0] mem [NUM_ANS];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, widx} < LIMIT)) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = ({1'b0, ridx} < LIMIT) ? mem[ridx] : '0;

endmodule

// File: rtl/multi_answer_checker.sv
// Bench-side checker: compares successive TEST_PORT writes against a table
// of expected answers, counting mismatches and RUN duration until done.
module multi_answer_checker
  import tb_check_pkg::*;
#(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                NUM_ANS   = 8,
  parameter int                IDX_W     = 3,
  parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'(DEFAULT_TEST_PORT),
  parameter logic [15:0]       TIMEOUT   = 16'd50000,
  parameter bit                BYTE_SWAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  multi_answer_checker_if.slave bus,
  output logic [7:0]         error_num,
  output logic [15:0]        duration,
  output logic [IDX_W:0]     ans_cnt,
  output logic               finish,
  output logic               pass,
  output logic               timeout
);

  localparam logic [IDX_W:0] NUM_ANS_C = (IDX_W+1)'(NUM_ANS);

  state_t            state, state_n;
  logic              wen_q;
  logic              accept;
  logic [DATA_W-1:0] cmp_data, exp_data;
  logic [MAX_DATA_W-1:0] swapped;
  logic [7:0]        error_num_n;
  logic [15:0]       duration_n;
  logic [IDX_W:0]    ans_cnt_n;
  logic              finish_n, pass_n, timeout_n;

  // Rising edge of wen only, so a write held through D-cache stalls counts once.
  assign accept   = bus.wen && !wen_q && (bus.addr == TEST_PORT);
  assign swapped  = byteswap(MAX_DATA_W'(bus.data), DATA_W / 8);
  assign cmp_data = BYTE_SWAP ? swapped[DATA_W-1:0] : bus.data;

  ans_table #(
    .NUM_ANS (NUM_ANS),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (bus.ld_en && (state == IDLE)),
    .widx  (bus.ld_idx),
    .wdata (bus.ld_data),
    .ridx  (ans_cnt[IDX_W-1:0]),
    .rdata (exp_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wen_q     <= 1'b0;
      error_num <= '0;
      duration  <= '0;
      ans_cnt   <= '0;
      finish    <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      wen_q     <= bus.wen;
      error_num <= error_num_n;
      duration  <= duration_n;
      ans_cnt   <= ans_cnt_n;
      finish    <= finish_n;
      pass      <= pass_n;
      timeout   <= timeout_n;
    end
  end

  // The final answer is checked before the timeout so it wins a same-cycle tie.
  always_comb begin
    state_n     = state;
    error_num_n = error_num;
    duration_n  = duration;
    ans_cnt_n   = ans_cnt;
    finish_n    = finish;
    pass_n      = pass;
    timeout_n   = timeout;
    if (state != DONE) begin
      if (state == RUN) begin
        duration_n = duration + 16'd1;
      end
      if (accept) begin
        ans_cnt_n = ans_cnt + 1'b1;
        if (cmp_data != exp_data && error_num != 8'hFF) begin
          error_num_n = error_num + 8'd1;
        end
        state_n = RUN;
      end
      if (accept && ans_cnt_n == NUM_ANS_C) begin
        state_n   = DONE;
        finish_n  = 1'b1;
        pass_n    = (error_num_n == 8'd0);
        timeout_n = 1'b0;
      end else if (state == RUN && duration_n == TIMEOUT) begin
        state_n   = DONE;
        finish_n  = 1'b1;
        pass_n    = 1'b0;
        timeout_n = 1'b1;
      end
    end
  end

`ifdef MULTI_ANSWER_CHECKER_VERBOSE
  always_ff @(posedge clk) begin
    if (rst && state != DONE && accept) begin
      $display("checker: idx=%0d expected=%h got=%h t=%0t", ans_cnt, exp_data, cmp_data, $time);
    end
    if (rst && state != DONE && state_n == DONE) begin
      $display("checker: %s errors=%0d timeout=%0b", pass_n ? "PASS" : "FAIL", error_num_n, timeout_n);
    end
  end
`endif

endmodule

// File: doc/multi_answer_checker.md
Name: multi_answer_checker

Overview:
- Parametrised bench-side result checker for the processor testbeds.
- Snoops the data-memory write bus and compares successive writes to a designated test port against a loadable table of NUM_ANS expected answers.
- Counts mismatches and measures run duration.
- Reports finish, pass and timeout; tolerates D-cache stalls that hold wen high for several cycles.

Parameters:
- ADDR_W, 30, word-address width of snooped bus
- DATA_W, 32, data width (multiple of 8)
- NUM_ANS, 8, number of expected answers (>=1)
- IDX_W, 3, table index width, >= clog2(NUM_ANS)
- TEST_PORT, 0, word address monitored
- TIMEOUT, 16'd50000, RUN cycles before timeout
- BYTE_SWAP, 1, 1 = reverse byte order of data before compare (little-endian bus)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  ADDR_W  snooped write address
- data  in  DATA_W  snooped write data
- wen  in  1  snooped write enable
- ld_en  in  1  expected-table write strobe
- ld_idx  in  IDX_W  table entry index
- ld_data  in  DATA_W  expected value (readable byte order)
- error_num  out  8  mismatch count
- duration  out  16  RUN-state cycle count
- ans_cnt  out  IDX_W+1  answers checked so far
- finish  out  1  check complete (pass, fail or timeout)
- pass  out  1  all NUM_ANS answers matched
- timeout  out  1  TIMEOUT reached first

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; error_num, duration, ans_cnt, finish, pass, timeout all 0; wen_q=0.
  - Expected table contents are undefined until loaded.
- All outputs are registered.
- Accepted write: wen & ~wen_q & (addr==TEST_PORT), where wen_q is wen delayed one cycle.
  - A write held across N stall cycles counts once.
  - A write to any other address is ignored, but still updates wen_q.
- cmp_data: data byte-reversed when BYTE_SWAP=1, else data unchanged.
- IDLE:
  - ld_en writes table[ld_idx] <= ld_data. ld_idx >= NUM_ANS is ignored.
  - An accepted write compares cmp_data against table[0], updates counters as in RUN, and moves to RUN.
  - If an accepted write and ld_en occur in the same cycle, the compare uses the pre-load entry and the load still takes effect.
  - duration stays 0 in IDLE.
- RUN:
  - duration increments every cycle.
  - ld_en is ignored.
  - On an accepted write: compare cmp_data with table[ans_cnt], ans_cnt+1; on mismatch error_num+1, saturating at 255.
  - When ans_cnt reaches NUM_ANS, go to DONE (latency: finish/pass high the cycle after the last accepted write).
  - If duration reaches TIMEOUT before that, go to DONE with timeout=1. If the final answer and timeout occur in the same cycle, the answer wins and timeout=0.
- DONE:
  - Terminal: all outputs frozen and all inputs ignored.
  - finish=1.
  - pass = (error_num==0) & ~timeout.
  - Leaving DONE requires rst.
- Reset mid-run returns to IDLE immediately. The expected table keeps its contents, so no reload is needed.
- Sim-only: $display of each accepted write (index, expected, got, $time) and one PASS/FAIL banner on entry to DONE. These are excluded from the synthesizable region.

Decomposition:
- Shared package tb_check_pkg holds:
  - state encoding typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - byteswap function;
  - default TEST_PORT constant.
- One sub-module, ans_table: NUM_ANS x DATA_W register file with 1 write port and 1 async read port.

Test Plan:
- Table loaded {60,1,2,3,4,5,6,7} (NUM_ANS=8); eight writes to addr 0 with matching byte-swapped data -> finish=1, pass=1, error_num=0, ans_cnt=8.
- Same table, 3rd write data=99 -> finish=1, pass=0, error_num=1.
- First write (value 60) held with wen high for 5 cycles, then 7 more correct writes -> ans_cnt=8, error_num=0; the stall counts once.
- Interleaved writes to addr 0x10 and 0x04 between answers -> ignored; ans_cnt increments only on TEST_PORT writes.
- TIMEOUT=100, only 3 answers written -> at duration=100: finish=1, timeout=1, pass=0, ans_cnt=3.
- rst pulsed after 4 answers, then 8 correct writes without reloading -> pass=1, and duration restarts from 0 at the first post-reset write.
